vend_controller: RTL and testbench
==================================

# vend_controller

Central sequencer of the vending machine. Accepts coins, keeps a running credit, and issues a one-cycle dispense pulse when a product is selected with enough credit. It then pays back any remaining credit one change coin per cycle. Its outputs drive the dispense and change-return set/reset flag latches. A cancel request refunds the whole credit through the same change path.

## Interface
Parameters:
- PRICE, 3, product price in 5-cent units (1..MAX_CREDIT)
- MAX_CREDIT, 10, maximum credit held, in 5-cent units
- CREDIT_W, 4, credit register width; must hold MAX_CREDIT+5

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle strobe, coin present on coin_type
- coin_type  in  2  coin code: 00 = 1 unit (5c), 01 = 2 units (10c), 10 = 5 units (25c), 11 = invalid
- select  in  1  one-cycle strobe, buy request
- cancel  in  1  one-cycle strobe, refund request
- credit  out  CREDIT_W  current credit in units
- coin_reject  out  1  one-cycle pulse, coin returned unaccepted
- short_credit  out  1  one-cycle pulse, select ignored because credit < PRICE
- dispense  out  1  one-cycle pulse, release product
- change_coin  out  1  one-cycle pulse, eject one 5c coin
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit = 0), COLLECT (credit > 0), VEND, CHANGE.
- Priority within COLLECT or IDLE, per cycle: cancel > select > coin.
  - If cancel or select is acted on, a coin in the same cycle is rejected.
- Coin handling in IDLE or COLLECT, with no higher-priority event:
  - A coin is accepted when the code is valid and credit + value ≤ MAX_CREDIT. Credit is updated and the FSM goes to COLLECT.
  - Otherwise coin_reject pulses and credit is unchanged.
- Select:
  - When credit ≥ PRICE, go to VEND.
  - Otherwise short_credit pulses and the state is unchanged.
  - Select in IDLE always gives short_credit, unless PRICE = 0, which is illegal.
- VEND lasts one cycle:
  - dispense = 1 and credit -= PRICE.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - Each cycle: change_coin = 1 and credit -= 1.
  - Go to IDLE on the cycle credit reaches 0.
- Cancel:
  - In COLLECT, go to CHANGE.
  - In IDLE, no effect.
- In VEND and CHANGE:
  - Coins are rejected with a coin_reject pulse.
  - select and cancel are ignored, with no short_credit.
- Arithmetic is unsigned at width CREDIT_W. Underflow is impossible by construction; the bench asserts credit ≤ MAX_CREDIT at all times.

## Timing
- Reset, asynchronous assert:
  - State = IDLE, credit = 0, all pulse outputs = 0, busy = 0.
  - Any credit held is lost.
  - Reset taken mid-CHANGE stops change ejection immediately.
- All outputs are registered and change only on a rising clk edge, except during reset.
- Coin strobe at edge N: credit shows the new value and coin_reject is high in cycle N+1.
- Select at edge N with sufficient credit:
  - dispense is high in cycle N+1, with credit already reduced by PRICE.
  - The first change_coin pulse is in cycle N+2.
- Change sequence: K remaining units give exactly K consecutive change_coin cycles. busy drops in the cycle after the last one.
- Latency from select to IDLE = 2 + remaining credit cycles.
- Strobes longer than one cycle are treated as repeated events.

## Structure
- Package vend_pkg holds:
  - coin code localparams and coin unit values
  - the state enum {IDLE, COLLECT, VEND, CHANGE}
  - the default PRICE and MAX_CREDIT
- One natural sub-module is credit_counter. It is a loadable add/subtract register with async active-low clear. Its controls are add_en with value, sub_en with value, and zero/ge-price flags.
- The FSM and output pulse registers stay in vend_controller.

## Test plan
- Reset, then coins 01 and 00, then select:
  - credit goes 2, then 3.
  - dispense pulses once; credit becomes 0; no change_coin; back to IDLE.
- Coin 10 (5 units), then select:
  - dispense pulses, credit becomes 2.
  - Exactly 2 change_coin pulses, then IDLE with busy = 0.
- Coins totalling 9, then coin 01:
  - coin_reject pulses and credit stays 9.
  - Coin type 11 at any time gives coin_reject.
- Credit 2, then select:
  - short_credit pulses and credit stays 2.
  - Then cancel gives 2 change_coin pulses, then IDLE.
- Credit 4, with select and coin 00 in the same cycle:
  - Vend proceeds and the coin is rejected.
  - Coins, select and cancel during CHANGE are rejected or ignored; the change count stays 1.
- Credit 5, select, then rst_n low during the 1st change_coin cycle:
  - All outputs go to 0 immediately, credit = 0, state IDLE.
  - No further change_coin after reset is released.

Source files
------------

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending machine sequencer:
//   - coin codes as they appear on coin_type, and their value in 5-cent units
//   - FSM state encoding
//   - default price / credit limit / credit register width
//   - coin_units(): maps a coin code to its value (0 for the invalid code)
// ---------------------------------------------------------------------------
package vend_pkg;

   localparam logic [1:0] COIN_5C  = 2'b00;
   localparam logic [1:0] COIN_10C = 2'b01;
   localparam logic [1:0] COIN_25C = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   localparam logic [2:0] UNITS_5C  = 3'd1;
   localparam logic [2:0] UNITS_10C = 3'd2;
   localparam logic [2:0] UNITS_25C = 3'd5;

   localparam int DEFAULT_PRICE      = 3;
   localparam int DEFAULT_MAX_CREDIT = 10;
   localparam int DEFAULT_CREDIT_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      VEND,
      CHANGE
   } state_t;

   function automatic logic [2:0] coin_units(input logic [1:0] code);
      case (code)
         COIN_5C:  return UNITS_5C;
         COIN_10C: return UNITS_10C;
         COIN_25C: return UNITS_25C;
         default:  return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/credit_counter.sv
// ---------------------------------------------------------------------------
// credit_counter
// Loadable add/subtract credit register with asynchronous active-low clear.
// Ports:
//   clk, rst_n        clock, async active-low clear
//   add_en, add_val   add add_val to the count (wins over sub_en)
//   sub_en, sub_val   subtract sub_val from the count
//   count             current credit
//   zero              count == 0
//   ge_price          count >= PRICE
// ---------------------------------------------------------------------------
module credit_counter
   import vend_pkg::*;
#(
   parameter int CREDIT_W = DEFAULT_CREDIT_W,
   parameter int PRICE    = DEFAULT_PRICE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                add_en,
   input  logic [CREDIT_W-1:0] add_val,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] sub_val,
   output logic [CREDIT_W-1:0] count,
   output logic                zero,
   output logic                ge_price
);

   localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (add_en) begin
         count <= count + add_val;
      end else if (sub_en) begin
         count <= count - sub_val;
      end
   end

   assign zero     = (count == '0);
   assign ge_price = (count >= PRICE_U);

endmodule

// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
// Central sequencer of the vending machine: collects coins into a running
// credit, vends when a product is selected with enough credit, then pays
// back the remainder one 5c coin per cycle. Cancel refunds the whole credit
// through the same change path.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   coin_valid     one-cycle strobe, coin present on coin_type
//   coin_type      00=1 unit, 01=2 units, 10=5 units, 11=invalid
//   select         buy request strobe
//   cancel         refund request strobe
//   credit         current credit in 5c units
//   coin_reject    pulse: coin returned unaccepted
//   short_credit   pulse: select ignored, credit below PRICE
//   dispense       pulse: release product
//   change_coin    pulse: eject one 5c coin
//   busy           high while vending or paying change
// ---------------------------------------------------------------------------
module vend_controller
   import vend_pkg::*;
#(
   parameter int PRICE      = DEFAULT_PRICE,
   parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
   parameter int CREDIT_W   = DEFAULT_CREDIT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                select,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                short_credit,
   output logic                dispense,
   output logic                change_coin,
   output logic                busy
);

   // One spare bit so credit + coin value can never wrap before the limit test.
   localparam logic [CREDIT_W:0]   MAX_U   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] ONE_U   = CREDIT_W'(1);

   state_t              state;
   logic                zero;
   logic                ge_price;
   logic                accepting;
   logic                do_cancel;
   logic                do_select;
   logic                buy;
   logic                coin_ok;
   logic                coin_take;
   logic                chg_step;
   logic [CREDIT_W:0]   coin_sum;
   logic                add_en;
   logic                sub_en;
   logic [CREDIT_W-1:0] add_val;
   logic [CREDIT_W-1:0] sub_val;

   always_comb begin
      accepting = (state == IDLE) || (state == COLLECT);
      // Cancel only matters with credit held; in IDLE it is not an event.
      do_cancel = (state == COLLECT) && cancel;
      do_select = accepting && select && !do_cancel;
      buy       = do_select && ge_price;
      coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin_type));
      coin_ok   = (coin_type != COIN_BAD) && (coin_sum <= MAX_U);
      coin_take = accepting && coin_valid && !do_cancel && !do_select && coin_ok;
      // A change coin leaves on the cancel edge itself, and on every edge of
      // VEND/CHANGE while credit remains.
      chg_step  = do_cancel || ((state == VEND || state == CHANGE) && !zero);
      add_en    = coin_take;
      add_val   = CREDIT_W'(coin_units(coin_type));
      sub_en    = buy || chg_step;
      sub_val   = buy ? PRICE_U : ONE_U;
   end

   credit_counter #(
      .CREDIT_W (CREDIT_W),
      .PRICE    (PRICE)
   ) u_credit (
      .clk      (clk),
      .rst_n    (rst_n),
      .add_en   (add_en),
      .add_val  (add_val),
      .sub_en   (sub_en),
      .sub_val  (sub_val),
      .count    (credit),
      .zero     (zero),
      .ge_price (ge_price)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         coin_reject  <= 1'b0;
         short_credit <= 1'b0;
         dispense     <= 1'b0;
         change_coin  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         coin_reject  <= coin_valid && !coin_take;
         short_credit <= do_select && !ge_price;
         dispense     <= buy;
         change_coin  <= chg_step;
         case (state)
            IDLE, COLLECT: begin
               busy <= do_cancel || buy;
               if (do_cancel) begin
                  state <= CHANGE;
               end else if (buy) begin
                  state <= VEND;
               end else if (coin_take) begin
                  state <= COLLECT;
               end
            end
            VEND, CHANGE: begin
               // credit already reflects the last deduction
               busy  <= !zero;
               state <= zero ? IDLE : CHANGE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_controller
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a payout-queue model of the vending rules.
// ---------------------------------------------------------------------------
module tb_vend_controller;

   localparam int PRICE = 3;
   localparam int MAXC  = 10;
   localparam int W     = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         coin_valid;
   logic [1:0]   coin_type;
   logic         select;
   logic         cancel;
   logic [W-1:0] credit;
   logic         coin_reject;
   logic         short_credit;
   logic         dispense;
   logic         change_coin;
   logic         busy;

   int total = 0;
   int bad   = 0;
   bit checking = 0;

   vend_controller #(
      .PRICE      (PRICE),
      .MAX_CREDIT (MAXC),
      .CREDIT_W   (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .select       (select),
      .cancel       (cancel),
      .credit       (credit),
      .coin_reject  (coin_reject),
      .short_credit (short_credit),
      .dispense     (dispense),
      .change_coin  (change_coin),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_plan counts change coins still owed; m_busy says the machine spent the
   // current cycle vending or paying, so inputs seen in it are not served.
   int m_credit = 0;
   int m_plan   = 0;
   bit m_busy   = 0;
   bit e_rej = 0, e_short = 0, e_disp = 0, e_chg = 0;
   int units [4] = '{1, 2, 5, 0};

   always @(posedge clk or negedge rst_n) begin
      bit busy_now;
      int v;
      if (!rst_n) begin
         m_credit = 0; m_plan = 0; m_busy = 0;
         e_rej = 0; e_short = 0; e_disp = 0; e_chg = 0;
      end else begin
         busy_now = m_busy;
         e_rej = 0; e_short = 0; e_disp = 0; e_chg = 0;
         m_busy = 0;
         v = units[coin_type];
         if (busy_now) begin
            if (coin_valid) e_rej = 1;
            if (m_plan > 0) begin
               m_plan--; m_credit--; e_chg = 1; m_busy = 1;
            end
         end else if (cancel && m_credit > 0) begin
            if (coin_valid) e_rej = 1;
            m_plan = m_credit - 1; m_credit--; e_chg = 1; m_busy = 1;
         end else if (select) begin
            if (coin_valid) e_rej = 1;
            if (m_credit >= PRICE) begin
               m_credit -= PRICE; m_plan = m_credit; e_disp = 1; m_busy = 1;
            end else begin
               e_short = 1;
            end
         end else if (coin_valid) begin
            if (v > 0 && m_credit + v <= MAXC) m_credit += v;
            else e_rej = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking) begin
         check("credit",       int'(credit),       m_credit);
         check("coin_reject",  int'(coin_reject),  int'(e_rej));
         check("short_credit", int'(short_credit), int'(e_short));
         check("dispense",     int'(dispense),     int'(e_disp));
         check("change_coin",  int'(change_coin),  int'(e_chg));
         check("busy",         int'(busy),         int'(m_busy));
         check("credit_bound", int'(int'(credit) <= MAXC), 1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit cv, input logic [1:0] ct, input bit sel, input bit can);
      coin_valid = cv; coin_type = ct; select = sel; cancel = can;
      @(posedge clk); #1;
      coin_valid = 0; coin_type = 2'b00; select = 0; cancel = 0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0);
   endtask

   initial begin
      rst_n = 0; coin_valid = 0; coin_type = 2'b00; select = 0; cancel = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_credit", int'(credit), 0);
      check("rst_busy",   int'(busy), 0);
      rst_n = 1;
      checking = 1;

      // 2 + 1 units, then exact-price vend with no change
      step(1, 2'b01, 0, 0);  check("s1_credit_a", int'(credit), 2);
      step(1, 2'b00, 0, 0);  check("s1_credit_b", int'(credit), 3);
      step(0, 2'b00, 1, 0);
      check("s1_disp", int'(dispense), 1);
      check("s1_credit_c", int'(credit), 0);
      step(0, 2'b00, 0, 0);
      check("s1_nochg", int'(change_coin), 0);
      check("s1_idle", int'(busy), 0);

      // 5 units, vend, two change coins
      step(1, 2'b10, 0, 0);  check("s2_credit", int'(credit), 5);
      step(0, 2'b00, 1, 0);
      check("s2_disp", int'(dispense), 1);
      check("s2_credit_v", int'(credit), 2);
      step(0, 2'b00, 0, 0);  check("s2_chg1", int'(change_coin), 1);
      step(0, 2'b00, 0, 0);  check("s2_chg2", int'(change_coin), 1);
      check("s2_credit_0", int'(credit), 0);
      step(0, 2'b00, 0, 0);
      check("s2_chg_end", int'(change_coin), 0);
      check("s2_busy", int'(busy), 0);

      // fill to 9, overflow coin and invalid coin rejected, then refund
      step(1, 2'b10, 0, 0);
      step(1, 2'b01, 0, 0);
      step(1, 2'b01, 0, 0);  check("s3_credit9", int'(credit), 9);
      step(1, 2'b01, 0, 0);
      check("s3_rej", int'(coin_reject), 1);
      check("s3_keep", int'(credit), 9);
      step(1, 2'b11, 0, 0);  check("s3_bad", int'(coin_reject), 1);
      step(0, 2'b00, 0, 1);  check("s3_cancel", int'(change_coin), 1);
      idle_n(10);
      check("s3_empty", int'(credit), 0);

      // short credit, then cancel refunds 2
      step(1, 2'b01, 0, 0);
      step(0, 2'b00, 1, 0);
      check("s4_short", int'(short_credit), 1);
      check("s4_keep", int'(credit), 2);
      step(0, 2'b00, 0, 1);  check("s4_chg1", int'(change_coin), 1);
      step(0, 2'b00, 0, 0);  check("s4_chg2", int'(change_coin), 1);
      step(0, 2'b00, 0, 0);  check("s4_done", int'(busy), 0);

      // select and coin together; disturbances during change
      step(1, 2'b01, 0, 0);
      step(1, 2'b01, 0, 0);
      step(1, 2'b00, 1, 0);
      check("s5_disp", int'(dispense), 1);
      check("s5_rej", int'(coin_reject), 1);
      check("s5_credit", int'(credit), 1);
      step(1, 2'b00, 1, 1);
      check("s5_chg", int'(change_coin), 1);
      check("s5_rej2", int'(coin_reject), 1);
      check("s5_noshort", int'(short_credit), 0);
      step(0, 2'b00, 0, 0);
      check("s5_one_chg", int'(change_coin), 0);
      check("s5_idle", int'(busy), 0);

      // reset during the first change coin
      step(1, 2'b10, 0, 0);
      step(0, 2'b00, 1, 0);
      step(0, 2'b00, 0, 0);  check("s6_chg", int'(change_coin), 1);
      #2 rst_n = 0;
      #1;
      check("s6_credit", int'(credit), 0);
      check("s6_chg0", int'(change_coin), 0);
      check("s6_busy", int'(busy), 0);
      check("s6_disp", int'(dispense), 0);
      check("s6_rej", int'(coin_reject), 0);
      check("s6_short", int'(short_credit), 0);
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         step(0, 2'b00, 0, 0);
         check("s6_after", int'(change_coin), 0);
      end

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 0;
            #1 rst_n = 1;
         end
         step($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      end

      checking = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
